// File: rtl/probe_logger.sv
// Multi-channel probe capture: arm/trigger/stop sequencer feeding a timestamped
// first-word-fall-through FIFO drained over a valid/ready stream.
module probe_logger #(
  parameter int                NUM_CH  = 2,
  parameter int                CH_W    = 1,
  parameter logic [NUM_CH-1:0] CH_MASK = {NUM_CH{1'b1}},
  parameter int                DEPTH   = 8,
  parameter int                TS_W    = 16,
  parameter int                DC_W    = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        arm,
  input  logic                        trig,
  input  logic                        stop,
  input  logic                        mode,
  input  logic [NUM_CH*CH_W-1:0]      probe_in,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [TS_W+NUM_CH*CH_W-1:0] out_data,
  output logic                        overflow,
  output logic [DC_W-1:0]             drop_count,
  output logic                        busy
);
  localparam int SW = NUM_CH * CH_W;
  localparam int DW = TS_W + SW;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_CAPTURE, S_STOPPED} state_t;

  state_t          state_q, state_d;
  logic [TS_W-1:0] ts_q, ts_d;
  logic [SW-1:0]   prev_q, prev_d;
  logic [SW-1:0]   sample_m;
  logic            overflow_q, overflow_d;
  logic [DC_W-1:0] drop_q, drop_d;
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q, count_d;
  logic [DW-1:0]   mem_q [DEPTH];
  logic            push, pop, full, wr_en, drop, clr_flags;

  always_comb begin
    sample_m = '0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      if (CH_MASK[ch]) sample_m[ch*CH_W +: CH_W] = probe_in[ch*CH_W +: CH_W];
    end
  end

  // Stream handshake: out_valid means the head entry is on out_data; the entry is
  // consumed on a rising edge where out_valid and out_ready are both high, and
  // out_data is held stable until then.
  assign full  = (count_q == CW'(DEPTH));
  assign pop   = (count_q != '0) && out_ready;
  assign wr_en = push && (!full || pop);
  assign drop  = push && full && !pop;

  always_comb begin
    state_d   = state_q;
    ts_d      = ts_q;
    prev_d    = prev_q;
    push      = 1'b0;
    clr_flags = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (arm) begin
          state_d   = S_ARMED;
          ts_d      = '0;
          clr_flags = 1'b1;
        end
      end
      S_ARMED: begin
        if (stop) begin
          state_d = S_IDLE;
        end else if (trig) begin
          state_d = S_CAPTURE;
          push    = 1'b1;
          prev_d  = sample_m;
          ts_d    = (ts_q == {TS_W{1'b1}}) ? ts_q : ts_q + TS_W'(1);
        end
      end
      S_CAPTURE: begin
        prev_d = sample_m;
        ts_d   = (ts_q == {TS_W{1'b1}}) ? ts_q : ts_q + TS_W'(1);
        if (stop) state_d = S_STOPPED;
        else      push    = mode || (sample_m != prev_q);
      end
      S_STOPPED: begin
        if (count_q == '0) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    overflow_d = overflow_q;
    drop_d     = drop_q;
    if (clr_flags) begin
      overflow_d = 1'b0;
      drop_d     = '0;
    end else if (drop) begin
      overflow_d = 1'b1;
      if (drop_q != {DC_W{1'b1}}) drop_d = drop_q + DC_W'(1);
    end
  end

  always_comb begin
    count_d = count_q;
    case ({wr_en, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      ts_q       <= '0;
      prev_q     <= '0;
      overflow_q <= 1'b0;
      drop_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      ts_q       <= ts_d;
      prev_q     <= prev_d;
      overflow_q <= overflow_d;
      drop_q     <= drop_d;
      count_q    <= count_d;
      if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)   rd_ptr_q <= rd_ptr_q + AW'(1);
    end
  end

  // Storage needs no reset: out_data is gated to zero whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= {ts_q, sample_m};
  end

  assign out_valid  = (count_q != '0);
  assign out_data   = out_valid ? mem_q[rd_ptr_q] : '0;
  assign overflow   = overflow_q;
  assign drop_count = drop_q;
  assign busy       = (state_q != S_IDLE);
endmodule

// File: tb/tb_probe_logger.sv
// Directed bench for probe_logger: a full-mask and a partial-mask instance share
// stimulus; each has its own expected-entry queue checked on every pop.
module tb_probe_logger;
  localparam int W = 18;

  logic         clk = 1'b0;
  logic         reset, arm, trig, stop, mode, out_ready;
  logic [1:0]   probe_in;
  logic         out_valid, overflow, busy;
  logic [W-1:0] out_data;
  logic [7:0]   drop_count;
  logic         out_valid_m, overflow_m, busy_m;
  logic [W-1:0] out_data_m;
  logic [7:0]   drop_count_m;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_m[$];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  probe_logger #(.NUM_CH(2), .CH_W(1), .CH_MASK(2'b11), .DEPTH(4), .TS_W(16), .DC_W(8)) u_dut (
    .clk(clk), .reset(reset), .arm(arm), .trig(trig), .stop(stop), .mode(mode),
    .probe_in(probe_in), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .overflow(overflow), .drop_count(drop_count), .busy(busy)
  );

  probe_logger #(.NUM_CH(2), .CH_W(1), .CH_MASK(2'b10), .DEPTH(4), .TS_W(16), .DC_W(8)) u_dut_m (
    .clk(clk), .reset(reset), .arm(arm), .trig(trig), .stop(stop), .mode(mode),
    .probe_in(probe_in), .out_valid(out_valid_m), .out_ready(out_ready), .out_data(out_data_m),
    .overflow(overflow_m), .drop_count(drop_count_m), .busy(busy_m)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_main(input int ts, input logic [1:0] d);
    exp_q.push_back({16'(ts), d});
  endtask

  task automatic push_mask(input int ts, input logic [1:0] d);
    exp_m.push_back({16'(ts), d});
  endtask

  // Compare any head about to be consumed, then advance to 1 time unit past the edge.
  task automatic tick();
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) check("main_unexpected_entry", out_valid, 1'b0);
      else                   check("main_data", out_data, exp_q.pop_front());
    end
    if (out_valid_m && out_ready) begin
      if (exp_m.size() == 0) check("mask_unexpected_entry", out_valid_m, 1'b0);
      else                   check("mask_data", out_data_m, exp_m.pop_front());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int i = 0; i < 30; i++) begin
      if (exp_q.size() == 0 && exp_m.size() == 0 && !busy && !busy_m) break;
      tick();
    end
    out_ready = 1'b0;
    check("main_queue_left", 64'(exp_q.size()), 64'd0);
    check("mask_queue_left", 64'(exp_m.size()), 64'd0);
    check("main_busy_after_drain", busy, 1'b0);
    check("main_valid_after_drain", out_valid, 1'b0);
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    #2;
    reset = 1'b1;
    exp_q.delete();
    exp_m.delete();
  endtask

  initial begin
    reset = 1'b0; arm = 1'b0; trig = 1'b0; stop = 1'b0; mode = 1'b0;
    out_ready = 1'b0; probe_in = 2'b00;
    #12;
    check("rst_valid", out_valid, 1'b0);
    check("rst_data", out_data, '0);
    check("rst_overflow", overflow, 1'b0);
    check("rst_drop", drop_count, 8'd0);
    check("rst_busy", busy, 1'b0);
    reset = 1'b1;
    @(posedge clk); #1;

    // Basic capture, every-cycle mode
    mode = 1'b1;
    arm = 1'b1; tick(); arm = 1'b0;
    check("armed_busy", busy, 1'b1);
    probe_in = 2'b01; trig = 1'b1;
    push_main(0, 2'b01); push_mask(0, 2'b00);
    tick(); trig = 1'b0;
    check("fwft_valid", out_valid, 1'b1);
    check("fwft_data", out_data, {16'd0, 2'b01});
    push_main(1, 2'b01); push_mask(1, 2'b00); tick();
    push_main(2, 2'b01); push_mask(2, 2'b00); tick();
    stop = 1'b1; tick(); stop = 1'b0;
    check("stopped_busy", busy, 1'b1);
    check("hold_data", out_data, {16'd0, 2'b01});
    drain();

    // Change-only capture
    pulse_reset();
    mode = 1'b0;
    arm = 1'b1; tick(); arm = 1'b0;
    trig = 1'b1; probe_in = 2'b00;
    push_main(0, 2'b00); push_mask(0, 2'b00);
    tick(); trig = 1'b0;
    probe_in = 2'b00; tick();
    probe_in = 2'b10; push_main(2, 2'b10); push_mask(2, 2'b10); tick();
    probe_in = 2'b10; tick();
    probe_in = 2'b11; push_main(4, 2'b11); tick();
    stop = 1'b1; tick(); stop = 1'b0;
    drain();

    // Masked channel toggling only, drained while capturing
    pulse_reset();
    mode = 1'b0; out_ready = 1'b1;
    arm = 1'b1; tick(); arm = 1'b0;
    trig = 1'b1; probe_in = 2'b00;
    push_main(0, 2'b00); push_mask(0, 2'b00);
    tick(); trig = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      probe_in = (i % 2 == 1) ? 2'b01 : 2'b00;
      push_main(i, probe_in);
      tick();
    end
    stop = 1'b1; tick(); stop = 1'b0;
    check("mask_drop", drop_count_m, 8'd0);
    drain();

    // Overflow with consumer stalled
    pulse_reset();
    mode = 1'b1; out_ready = 1'b0; probe_in = 2'b01;
    arm = 1'b1; tick(); arm = 1'b0;
    trig = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i < 4) begin
        push_main(i, 2'b01); push_mask(i, 2'b00);
      end
      tick();
      trig = 1'b0;
    end
    stop = 1'b1; tick(); stop = 1'b0;
    check("ovf_flag", overflow, 1'b1);
    check("ovf_drop", drop_count, 8'd2);
    check("ovf_drop_mask", drop_count_m, 8'd2);
    drain();
    check("ovf_sticky", overflow, 1'b1);
    arm = 1'b1; tick(); arm = 1'b0;
    check("arm_clears_ovf", overflow, 1'b0);
    check("arm_clears_drop", drop_count, 8'd0);
    stop = 1'b1; tick(); stop = 1'b0;
    check("armed_stop_idle", busy, 1'b0);

    // Full FIFO with simultaneous push and pop
    mode = 1'b1; probe_in = 2'b10;
    arm = 1'b1; tick(); arm = 1'b0;
    trig = 1'b1;
    for (int i = 0; i < 4; i++) begin
      push_main(i, 2'b10); push_mask(i, 2'b10);
      tick();
      trig = 1'b0;
    end
    probe_in = 2'b11; out_ready = 1'b1;
    push_main(4, 2'b11); push_mask(4, 2'b10);
    tick();
    out_ready = 1'b0;
    stop = 1'b1; tick(); stop = 1'b0;
    check("full_pp_overflow", overflow, 1'b0);
    check("full_pp_drop", drop_count, 8'd0);
    check("full_pp_head", out_data, {16'd1, 2'b10});
    drain();

    // Asynchronous reset mid-capture
    mode = 1'b1; probe_in = 2'b11;
    arm = 1'b1; tick(); arm = 1'b0;
    trig = 1'b1; tick(); trig = 1'b0;
    tick(); tick();
    check("pre_rst_valid", out_valid, 1'b1);
    reset = 1'b0;
    #1;
    check("async_rst_valid", out_valid, 1'b0);
    check("async_rst_busy", busy, 1'b0);
    check("async_rst_drop", drop_count, 8'd0);
    check("async_rst_data", out_data, '0);
    exp_q.delete(); exp_m.delete();
    reset = 1'b1;
    tick();
    probe_in = 2'b01;
    arm = 1'b1; tick(); arm = 1'b0;
    trig = 1'b1;
    push_main(0, 2'b01); push_mask(0, 2'b00);
    tick(); trig = 1'b0;
    check("restart_ts0", out_data, {16'd0, 2'b01});
    stop = 1'b1; tick(); stop = 1'b0;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/probe_logger.md
Name: probe_logger

Overview:
Parametrised multi-channel probe capture block. It samples NUM_CH probe channels of CH_W bits each and gates each channel with a compile-time enable mask. Once armed and triggered, it captures timestamped samples into an internal FIFO, either on every cycle or only when a sample changes. The FIFO drains through a valid/ready stream. The block sits beside a DUT inside testbenches and debug wrappers, and replaces ad-hoc per-signal logging blocks.

Parameters:
NUM_CH, 2, number of probe channels
CH_W, 1, width of each channel in bits
CH_MASK, all ones (NUM_CH bits), per-channel enable; bit i = 0 excludes channel i
DEPTH, 8, FIFO entries; power of two, minimum 2
TS_W, 16, timestamp width
DC_W, 8, drop counter width

Ports:
clk  in  1  clock; all logic is on the rising edge
reset  in  1  asynchronous, active-low reset
arm  in  1  pulse: IDLE->ARMED
trig  in  1  starts capture while ARMED
stop  in  1  ends capture
mode  in  1  0 = capture on change, 1 = capture every cycle; sampled each cycle
probe_in  in  NUM_CH*CH_W  channel i occupies bits [i*CH_W +: CH_W]
out_valid  out  1  FIFO head valid
out_ready  in  1  consumer accepts the head
out_data  out  TS_W+NUM_CH*CH_W  {timestamp, masked sample}
overflow  out  1  sticky flag: an entry was dropped
drop_count  out  DC_W  number of dropped entries, saturating
busy  out  1  state is not IDLE

Behaviour:
- Reset (reset=0, asynchronous): state IDLE, FIFO empty, out_valid=0, out_data=0, overflow=0, drop_count=0, timestamp=0, prev sample=0, busy=0.
- Masked sample: channel i is forced to 0 when CH_MASK[i]=0. The masked sample is both the value stored and the value compared.
- IDLE:
  - arm=1 -> ARMED.
  - On that edge: timestamp <- 0, overflow <- 0, drop_count <- 0.
  - The FIFO contents are kept.
- ARMED:
  - stop=1 -> IDLE. stop has priority over trig.
  - Otherwise trig=1 -> CAPTURE, and the sample from this same cycle is pushed with timestamp 0.
- CAPTURE:
  - The timestamp increments every cycle and saturates at 2^TS_W-1.
  - Push condition: mode=1, or the masked sample differs from prev.
  - prev updates every cycle.
  - stop=1 -> STOPPED, and the sample from the stop cycle is not pushed.
  - arm and trig are ignored.
- STOPPED: -> IDLE in the first cycle that the FIFO is empty. arm is ignored until IDLE.
- FIFO:
  - First-word fall-through.
  - A sample pushed at edge N is visible with out_valid=1 after edge N.
  - out_data holds its value while out_valid=1 and out_ready=0.
  - out_data=0 when the FIFO is empty.
- Pop: occurs when out_valid and out_ready are both 1.
- Simultaneous push and pop:
  - Allowed at any occupancy, including full.
  - When full, a push in the same cycle as a pop succeeds and is not dropped.
- Full, push with no pop:
  - The entry is dropped.
  - overflow <- 1.
  - drop_count increments and saturates at 2^DC_W-1.
  - The FIFO is unchanged.
- Entry order is strictly FIFO. Pointers wrap modulo DEPTH. A count register of width log2(DEPTH)+1 distinguishes full from empty.
- Asynchronous reset at any time, including mid-capture or mid-drain, returns every output to its reset value immediately.

Test Plan:
- Basic capture: NUM_CH=2, CH_W=1, mode=1. arm, then trig at cycle 0 with probe_in=2'b01. Hold 3 cycles, then stop -> 3 entries with ts 0,1,2 and data 01; busy returns to 0 after the drain.
- Change mode: mode=0, probe sequence 00,00,10,10,11 from trigger -> entries (ts0,00), (ts2,10), (ts4,11); no others.
- Mask: CH_MASK=2'b10, mode=0, probe toggles only bit0 -> single entry at ts0, with bit0 stored as 0.
- Overflow: DEPTH=4, mode=1, out_ready=0, capture 6 cycles -> 4 entries ts0..3, overflow=1, drop_count=2. A subsequent arm in IDLE clears both.
- Full with simultaneous push and pop: FIFO full, out_ready=1 for one cycle during capture -> ts0 popped, new entry accepted, overflow stays 0, count stays 4.
- Reset mid-capture: assert reset low in CAPTURE with 3 entries -> out_valid=0, busy=0, drop_count=0 asynchronously; after release, arm+trig restarts at ts0.
